// File: rtl/sha256_digest_uart_tx_pkg.sv
// Shared constants and the UART frame state encoding for the digest return path.
// Imported by the interface, the byte transmitter and the top level.
package sha_uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_FRAME_BITS      = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DIGEST_W             = 256;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/sha256_digest_uart_tx_if.sv
// Digest-in / serial-out bundle between the SHA core side and the UART return path.
// master = SHA core side (and bench), slave = the serializer.
interface sha256_digest_uart_tx_if;
  import sha_uart_pkg::*;

  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                uart_txd;
  logic                busy;
  logic                done;
  logic                overrun;

  modport master (
    output digest, digest_valid,
    input  uart_txd, busy, done, overrun
  );

  modport slave (
    input  digest, digest_valid,
    output uart_txd, busy, done, overrun
  );

endinterface

// File: rtl/sha256_digest_uart_tx_byte.sv
// 8N1 byte transmitter: bit timer plus START/DATA/STOP frame FSM, LSB first.
// tx_done flags the final cycle of the stop bit so a queued byte can follow with no gap.
module uart_tx_byte
  import sha_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      txd
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state;
  logic [TW-1:0]             timer;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      bit_end;

  assign bit_end = (timer == T_LAST);
  assign tx_done = (state == STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else if (state == IDLE) begin
      timer <= '0;
      if (tx_start) begin
        shreg   <= tx_data;
        state   <= START;
        txd     <= 1'b0;
        tx_busy <= 1'b1;
      end
    end else if (!bit_end) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
      case (state)
        START: begin
          state   <= DATA;
          bit_idx <= '0;
          txd     <= shreg[0];
          shreg   <= shreg >> 1;
        end
        DATA: begin
          if (bit_idx == BIT_LAST) begin
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        STOP: begin
          // Chain straight into the next start bit when another byte is queued.
          if (tx_start) begin
            shreg <= tx_data;
            state <= START;
            txd   <= 1'b0;
          end else begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          txd     <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sha256_digest_uart_tx.sv
// Captures a SHA digest on the rising edge of digest_valid and streams it MSB byte first
// over an 8N1 UART; flags digests that arrive while a transfer is still in flight.
module sha256_digest_uart_tx
  import sha_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DIGEST_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  sha256_digest_uart_tx_if.slave  bus
);

  localparam int BW = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(DIGEST_BYTES - 1);

  logic                      dv_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      overrun_q;
  logic [DIGEST_W-1:0]       sreg;
  logic [BW-1:0]             byte_cnt;

  logic                      new_dig;
  logic                      capture;
  logic                      last_byte;
  logic                      tx_start;
  logic                      tx_done;
  logic                      tx_busy;
  logic                      txd;
  logic [UART_DATA_BITS-1:0] tx_data;

  assign new_dig   = bus.digest_valid & ~dv_q;
  // The done cycle still counts as busy, so an edge landing on it is an overrun.
  assign capture   = new_dig & ~busy_q & ~done_q & ~tx_busy;
  assign last_byte = (byte_cnt == BYTE_LAST);
  assign tx_start  = capture | (tx_done & ~last_byte);

  // Byte 0 comes straight off the input on capture; later bytes are the next one up in sreg.
  assign tx_data = capture ? bus.digest[DIGEST_W-1 -: UART_DATA_BITS]
                           : sreg[DIGEST_W-UART_DATA_BITS-1 -: UART_DATA_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      sreg      <= '0;
      byte_cnt  <= '0;
    end else begin
      dv_q      <= bus.digest_valid;
      done_q    <= 1'b0;
      overrun_q <= new_dig & (busy_q | done_q);
      if (capture) begin
        sreg     <= bus.digest;
        byte_cnt <= '0;
        busy_q   <= 1'b1;
      end else if (tx_done) begin
        if (last_byte) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          sreg     <= sreg << UART_DATA_BITS;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .txd      (txd)
  );

  assign bus.uart_txd = txd;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overrun  = overrun_q;

endmodule
